cpu_fetch_decode: RTL

- Fetch/decode sequencer directly upstream of the CPU coverage/monitor module.
- Consumes a 16-bit instruction word stream with a valid/ready handshake.
- Assembles one- or two-word instructions and decodes the target resource.
- Drives addr, data, instr, mode and resource (package types instr_e, mode_e, resource_e), one decoded instruction at a time, qualified by out_valid/out_ready.

---
 rtl/cpu_fetch_decode_if.sv | 60 ++++++
 rtl/cpu_fetch_decode.sv | 129 ++++++++++++
 2 files changed

// File: rtl/cpu_fetch_decode_if.sv
// Shared cpu encodings and the stream/decoded-instruction bus between the
// instruction source, the fetch/decode sequencer and the downstream monitor.
package cpu_pkg;
    typedef enum logic [2:0] {
        NOP   = 3'd0,
        LOAD  = 3'd1,
        STORE = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        JMP   = 3'd5,
        HALT  = 3'd7
    } instr_e;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALTED  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        RAM  = 2'd1,
        ROM  = 2'd2,
        IO   = 2'd3
    } resource_e;
endpackage

interface cpu_fetch_decode_if #(
    parameter int ERR_W = 8
);
    import cpu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_word;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      addr;
    logic [15:0]      data;
    instr_e           instr;
    mode_e            mode;
    resource_e        resource;
    logic             illegal_op;
    logic [ERR_W-1:0] err_cnt;

    // master: word source and decoded-instruction consumer
    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, addr, data, instr, mode, resource,
               illegal_op, err_cnt
    );

    // slave: the sequencer itself
    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, addr, data, instr, mode, resource,
               illegal_op, err_cnt
    );
endinterface

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode sequencer: assembles one- or two-word instructions from a
// 16-bit word stream and presents one decoded instruction at a time.
module cpu_fetch_decode
    import cpu_pkg::*;
#(
    parameter logic [3:0] IO_NIBBLE = 4'hF,
    parameter int         ERR_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    cpu_fetch_decode_if.slave  bus
);

    localparam logic [2:0] OP_ILLEGAL = 3'd6;

    mode_e            state_reg;
    instr_e           pend_op_reg;
    logic [12:0]      pend_imm_reg;
    logic             out_valid_reg;
    logic [15:0]      addr_reg;
    logic [15:0]      data_reg;
    instr_e           instr_reg;
    resource_e        resource_reg;
    logic             illegal_reg;
    logic [ERR_W-1:0] err_cnt_reg;

    logic             in_ready_next;
    logic             in_xfer;
    logic [2:0]       in_op;
    logic             in_two_word;

    function automatic resource_e decode_resource(input instr_e op, input logic [15:0] a);
        resource_e r;
        r = NONE;
        case (op)
            LOAD, STORE, ADD, SUB: begin
                if (!a[15])
                    r = RAM;
                else if (a[15:12] == IO_NIBBLE)
                    r = IO;
                else
                    r = ROM;
            end
            default: r = NONE;
        endcase
        return r;
    endfunction

    // Ready depends only on state so the upstream never sees a valid->ready loop.
    always_comb begin
        in_ready_next = 1'b0;
        if (state_reg == FETCH || state_reg == DECODE)
            in_ready_next = 1'b1;
    end

    assign in_xfer     = bus.in_valid && in_ready_next;
    assign in_op       = bus.in_word[15:13];
    assign in_two_word = (in_op >= 3'd1) && (in_op <= 3'd5);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= FETCH;
            pend_op_reg   <= NOP;
            pend_imm_reg  <= '0;
            out_valid_reg <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            instr_reg     <= NOP;
            resource_reg  <= NONE;
            illegal_reg   <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            illegal_reg <= 1'b0;
            case (state_reg)
                FETCH: begin
                    if (in_xfer) begin
                        if (in_op == OP_ILLEGAL) begin
                            illegal_reg <= 1'b1;
                            if (!(&err_cnt_reg))
                                err_cnt_reg <= err_cnt_reg + 1'b1;
                        end else if (in_two_word) begin
                            pend_op_reg  <= instr_e'(in_op);
                            pend_imm_reg <= bus.in_word[12:0];
                            state_reg    <= DECODE;
                        end else begin
                            addr_reg      <= '0;
                            data_reg      <= {3'b000, bus.in_word[12:0]};
                            instr_reg     <= instr_e'(in_op);
                            resource_reg  <= NONE;
                            out_valid_reg <= 1'b1;
                            state_reg     <= EXECUTE;
                        end
                    end
                end
                DECODE: begin
                    if (in_xfer) begin
                        addr_reg      <= bus.in_word;
                        data_reg      <= {3'b000, pend_imm_reg};
                        instr_reg     <= pend_op_reg;
                        resource_reg  <= decode_resource(pend_op_reg, bus.in_word);
                        out_valid_reg <= 1'b1;
                        state_reg     <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= (instr_reg == HALT) ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_next;
    assign bus.out_valid  = out_valid_reg;
    assign bus.addr       = addr_reg;
    assign bus.data       = data_reg;
    assign bus.instr      = instr_reg;
    assign bus.mode       = state_reg;
    assign bus.resource   = resource_reg;
    assign bus.illegal_op = illegal_reg;
    assign bus.err_cnt    = err_cnt_reg;

endmodule
